// File: rtl/vedic_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : vedic_mac_pipe
// Brief    : Two-stage pipelined Vedic multiply-accumulate with valid/ready
//            stream handshake, signed/unsigned mode and sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module vedic_mac_pipe #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   signed_mode,
    input  logic                   acc_en,
    input  logic                   acc_clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     product,
    output logic [ACC_WIDTH-1:0]   acc,
    output logic                   acc_ovf
);

    localparam int c_NIB = WIDTH / 4;
    localparam int c_PW  = 2 * WIDTH;
    localparam int c_NPP = c_NIB * c_NIB;

    // 2x2 Vedic cell: vertical/crosswise terms resolved with two half adders.
    function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
        logic cross_s, cross_c, top;
        cross_s = (x[1] & y[0]) ^ (x[0] & y[1]);
        cross_c = (x[1] & y[0]) & (x[0] & y[1]);
        top     = x[1] & y[1];
        return {top & cross_c, top ^ cross_c, cross_s, x[0] & y[0]};
    endfunction

    function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0, q1, q2, q3;
        q0 = vedic2(x[1:0], y[1:0]);
        q1 = vedic2(x[3:2], y[1:0]);
        q2 = vedic2(x[1:0], y[3:2]);
        q3 = vedic2(x[3:2], y[3:2]);
        return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
    endfunction

    logic                  w_advance;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [WIDTH-1:0]      w_mag_a;
    logic [WIDTH-1:0]      w_mag_b;
    logic [7:0]            w_pp [c_NPP];

    logic                  r_s1_valid;
    logic                  r_neg;
    logic                  r_sgn;
    logic                  r_en;
    logic                  r_clr;
    logic [7:0]            r_pp [c_NPP];

    logic [c_PW-1:0]       w_mag;
    logic [c_PW-1:0]       w_prod;
    logic [ACC_WIDTH-1:0]  w_ext;
    logic [ACC_WIDTH:0]    w_sum;
    logic                  w_sov;
    logic                  w_ovf;

    logic                  r_out_valid;
    logic [c_PW-1:0]       r_product;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic                  r_ovf;

    assign w_advance = !r_out_valid | out_ready;
    assign in_ready  = w_advance;

    // The most negative operand negates to itself, which reads correctly as
    // the unsigned magnitude 2^(WIDTH-1).
    assign w_a_neg = signed_mode & a[WIDTH-1];
    assign w_b_neg = signed_mode & b[WIDTH-1];
    assign w_mag_a = w_a_neg ? (~a + 1'b1) : a;
    assign w_mag_b = w_b_neg ? (~b + 1'b1) : b;

    generate
        for (genvar gi = 0; gi < c_NIB; gi++) begin : g_row
            for (genvar gj = 0; gj < c_NIB; gj++) begin : g_col
                assign w_pp[gi*c_NIB + gj] = vedic4(w_mag_a[4*gi +: 4], w_mag_b[4*gj +: 4]);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_neg      <= 1'b0;
            r_sgn      <= 1'b0;
            r_en       <= 1'b0;
            r_clr      <= 1'b0;
            for (int k = 0; k < c_NPP; k++) r_pp[k] <= '0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            r_neg      <= w_a_neg ^ w_b_neg;
            r_sgn      <= signed_mode;
            r_en       <= acc_en;
            r_clr      <= acc_clear;
            for (int k = 0; k < c_NPP; k++) r_pp[k] <= w_pp[k];
        end
    end

    always_comb begin
        w_mag = '0;
        for (int k = 0; k < c_NPP; k++) begin
            w_mag = w_mag + (c_PW'(r_pp[k]) << (4 * ((k / c_NIB) + (k % c_NIB))));
        end
    end

    assign w_prod = r_neg ? (~w_mag + 1'b1) : w_mag;

    always_comb begin
        w_ext = {ACC_WIDTH{r_sgn & w_prod[c_PW-1]}};
        w_ext[c_PW-1:0] = w_prod;
    end

    assign w_sum = {1'b0, r_acc} + {1'b0, w_ext};
    assign w_sov = (r_acc[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &
                   (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
    assign w_ovf = r_sgn ? w_sov : w_sum[ACC_WIDTH];

    // Accumulator only moves on a valid beat leaving S1, so stalls and
    // bubbles can never re-add or corrupt it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_product   <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_product <= w_prod;
                if (r_clr) begin
                    r_acc <= w_ext;
                    r_ovf <= 1'b0;
                end else if (r_en) begin
                    r_acc <= w_sum[ACC_WIDTH-1:0];
                    r_ovf <= r_ovf | w_ovf;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign acc       = r_acc;
    assign acc_ovf   = r_ovf;

endmodule
`default_nettype wire
